// File: rtl/serial_subtractor_pkg.sv
// ---------------------------------------------------------------------------
// serial_subtractor_pkg
//   Shared definitions for the bit-serial subtractor:
//     - DEFAULT_WIDTH : default operand/result width
//     - ST_*          : 2-bit binary FSM state encodings
//     - signed_ovf()  : two's complement overflow rule for a - b
// ---------------------------------------------------------------------------
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // a - b overflows only when the operand signs differ and the result
  // sign disagrees with the minuend sign.
  function automatic logic signed_ovf(input logic a_msb,
                                      input logic b_msb,
                                      input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/serial_subtractor_fs_df.sv
// ---------------------------------------------------------------------------
// fs_df
//   Dataflow single-bit full subtractor (a - b - bin).
//   Ports:
//     a    : minuend bit
//     b    : subtrahend bit
//     bin  : borrow in
//     diff : difference bit
//     bout : borrow out
// ---------------------------------------------------------------------------
module fs_df (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  // Borrow when a=0,b=1, or when the bits are equal and a borrow ripples in.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor, diff = a - b, LSB first, one bit per
//   clock, using a single full-subtractor cell and a registered borrow.
//   Ports:
//     clk        : rising-edge clock
//     rst_n      : synchronous active-low reset
//     start      : request, sampled only while idle
//     a, b       : minuend / subtrahend, captured on the accepting edge
//     busy       : high while an operation is in flight (SHIFT or DONE)
//     done       : one-cycle pulse, result outputs valid
//     diff       : a - b modulo 2^WIDTH
//     borrow_out : final borrow (a < b unsigned)
//     ovf        : signed overflow of a - b
// ---------------------------------------------------------------------------
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  // Counter holds 0..WIDTH-1, so clog2(WIDTH) bits suffice (5 bits at 32).
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_sh_r;
  logic [CW-1:0]    cnt_r;
  logic             bor_r;
  logic             a_msb_r;
  logic             b_msb_r;
  logic [WIDTH-1:0] diff_r;
  logic             borrow_out_r;
  logic             ovf_r;
  logic             done_r;
  logic             d_s;
  logic             bout_s;
  logic             last_s;
  logic [WIDTH-1:0] res_nxt_s;

  // Single full-subtractor cell working on the current LSBs.
  fs_df u_fs (
    .a    (a_sh_r[0]),
    .b    (b_sh_r[0]),
    .bin  (bor_r),
    .diff (d_s),
    .bout (bout_s)
  );

  assign last_s    = (cnt_r == CNT_LAST);
  // New difference bit enters at the MSB so the LSB-first stream lands in place.
  assign res_nxt_s = {d_s, res_sh_r[WIDTH-1:1]};

  // Next-state logic for the IDLE/SHIFT/DONE controller.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_SHIFT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register, operand/result shifters, counter, borrow and outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      a_sh_r       <= '0;
      b_sh_r       <= '0;
      res_sh_r     <= '0;
      cnt_r        <= CNT_ZERO;
      bor_r        <= 1'b0;
      a_msb_r      <= 1'b0;
      b_msb_r      <= 1'b0;
      diff_r       <= '0;
      borrow_out_r <= 1'b0;
      ovf_r        <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_sh_r  <= a;
            b_sh_r  <= b;
            bor_r   <= 1'b0;
            cnt_r   <= CNT_ZERO;
            a_msb_r <= a[WIDTH-1];
            b_msb_r <= b[WIDTH-1];
          end else begin
            cnt_r   <= cnt_r;
          end
        end
        ST_SHIFT: begin
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          res_sh_r <= res_nxt_s;
          bor_r    <= bout_s;
          cnt_r    <= cnt_r + CNT_ONE;
          // Publish the complete result only on the edge entering DONE,
          // so the visible outputs never show a partial difference.
          if (last_s) begin
            diff_r       <= res_nxt_s;
            borrow_out_r <= bout_s;
            ovf_r        <= signed_ovf(a_msb_r, b_msb_r, d_s);
            done_r       <= 1'b1;
          end else begin
            done_r       <= 1'b0;
          end
        end
        ST_DONE: begin
          done_r <= 1'b0;
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = (state_r != ST_IDLE);
  assign done       = done_r;
  assign diff       = diff_r;
  assign borrow_out = borrow_out_r;
  assign ovf        = ovf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// ---------------------------------------------------------------------------
// tb_serial_subtractor
//   Directed self-checking bench for serial_subtractor with WIDTH=8.
// ---------------------------------------------------------------------------
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow_out;
  logic       ovf;

  int n_checks;
  int n_pass;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller is 1 time unit after an edge with the DUT idle.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] ed, input logic eb, input logic eo);
    int   edges;
    int   busy_n;
    logic seen;
    a = av; b = bv; start = 1'b1;
    tick();                      // accepting edge
    start = 1'b0;
    edges = 0; busy_n = 0; seen = 1'b0;
    while (!seen && edges < 40) begin
      if (busy) busy_n++;
      if (done) begin
        seen = 1'b1;
      end else begin
        tick();
        edges++;
      end
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " latency_edges"}, 32'(edges + 1), 32'd9);
    check({tag, " busy_cycles"}, 32'(busy_n), 32'd9);
    check({tag, " diff"}, 32'(diff), 32'(ed));
    check({tag, " borrow_out"}, 32'(borrow_out), 32'(eb));
    check({tag, " ovf"}, 32'(ovf), 32'(eo));
    tick();
    check({tag, " done_cleared"}, 32'(done), 32'd0);
    check({tag, " back_idle"}, 32'(busy), 32'd0);
    check({tag, " diff_held"}, 32'(diff), 32'(ed));
  endtask

  initial begin
    int done_n;
    int last_done;
    int low_n;
    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
    tick(); tick();
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst diff", 32'(diff), 32'd0);
    check("rst borrow", 32'(borrow_out), 32'd0);
    check("rst ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    tick();

    run_op("5A-23", 8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
    run_op("00-01", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    run_op("80-01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op("FF-FF", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    run_op("7F-80", 8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1);

    // Second request and operand changes during SHIFT must be ignored.
    a = 8'h10; b = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("midop diff_not_partial", 32'(diff), 32'hFF);
    a = 8'hFF; b = 8'h00; start = 1'b1;
    tick();
    start = 1'b0; a = 8'h55; b = 8'hAA;
    done_n = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) begin
        done_n++;
        check("midop diff", 32'(diff), 32'h0F);
      end
      tick();
    end
    check("midop done_count", 32'(done_n), 32'd1);

    // Reset in the middle of an operation aborts it.
    a = 8'hF0; b = 8'h0F; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort diff", 32'(diff), 32'd0);
    check("abort borrow", 32'(borrow_out), 32'd0);
    check("abort ovf", 32'(ovf), 32'd0);
    done_n = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) done_n++;
      tick();
    end
    check("abort no_activity", 32'(done_n), 32'd0);
    run_op("F0-0F", 8'hF0, 8'h0F, 8'hE1, 1'b0, 1'b0);

    // Back-to-back operations with start held high.
    a = 8'h09; b = 8'h03; start = 1'b1;
    done_n = 0; last_done = -1; low_n = 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (!busy) low_n++;
      if (done) begin
        check("hold diff", 32'(diff), 32'h06);
        if (last_done >= 0) begin
          check("hold period", 32'(i - last_done), 32'd10);
          check("hold busy_low", 32'(low_n), 32'd1);
        end
        last_done = i;
        low_n = 0;
        done_n++;
      end
    end
    start = 1'b0;
    check("hold done_count", 32'(done_n), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial WIDTH-bit subtractor computing diff = a - b, LSB first, one bit per clock. It is the subtract-direction counterpart of the team's dataflow full adder. A single full-subtractor cell is reused with a registered borrow, trading latency for area. It sits beside the ripple-carry adder datapath and uses a start/busy/done handshake toward a controlling FSM.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request. Sampled only in IDLE.
- a  input  WIDTH  minuend. Captured on the accepting edge.
- b  input  WIDTH  subtrahend. Captured on the accepting edge.
- busy  output  1  high while in SHIFT or DONE.
- done  output  1  one-cycle pulse. Result valid.
- diff  output  WIDTH  a - b modulo 2^WIDTH.
- borrow_out  output  1  final borrow. 1 when a < b, unsigned.
- ovf  output  1  signed (two's complement) overflow of a - b.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-low on rst_n. Every register updates on the rising edge of clk.
- Reset (rst_n=0 at an edge):
  - state=IDLE.
  - busy=0, done=0.
  - diff=0, borrow_out=0, ovf=0.
  - Internal shift registers, bit counter and borrow flop are all cleared.
  - Reset mid-operation aborts the operation. No done pulse is produced for it.
- States: IDLE, SHIFT, DONE. Encoding is 2-bit binary.
- IDLE:
  - If start=1 at an edge: load a_sh=a, b_sh=b, bor=0, cnt=0, capture a_msb and b_msb, then go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, each edge:
  - d = a_sh[0] ^ b_sh[0] ^ bor.
  - bor <= (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bor).
  - a_sh and b_sh shift right by one. The result shift register shifts right with d entering at the MSB.
  - cnt increments. On the edge where cnt == WIDTH-1, go to DONE.
- DONE, entered after exactly WIDTH SHIFT edges:
  - diff holds the full result.
  - borrow_out = final bor.
  - ovf = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb).
  - done=1 for exactly this one cycle. Next edge goes to IDLE.
- Latency: start accepted at edge E. done is high in the cycle following edge E+WIDTH, i.e. WIDTH+1 edges from acceptance to done.
- Throughput: one result per WIDTH+2 cycles.
- Operand capture: a and b are captured once, at acceptance. Changes to a and b afterwards have no effect.
- start is ignored while busy=1, including during the DONE cycle. A start held high through DONE is accepted on the first IDLE edge.
- Output holding:
  - diff, borrow_out and ovf update only on the edge entering DONE.
  - They hold their values until the next operation's DONE or until reset.
  - They do not show partial values during SHIFT. The result is accumulated in an internal register and copied on entry to DONE.
- busy = (state != IDLE). It is combinational from the state register.
- Boundary cases:
  - a == b gives diff=0, borrow_out=0.
  - a=0, b=2^WIDTH-1 gives diff=1, borrow_out=1.
  - Counter width is clog2(WIDTH), computed from the parameter; with WIDTH=32 the counter must not wrap early.

Decomposition:
- Shared include file (e.g. subtractor_defs.vh) holds the state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2 and the default width constant.
- One natural sub-module: fs_df, a dataflow full subtractor.
  - Inputs a, b, bin. Outputs diff and bout.
  - diff = a^b^bin; bout = ~a&b | ~(a^b)&bin.
  - Instantiated once in the SHIFT datapath.
- The FSM, counter and shift registers stay in serial_subtractor.

Test Plan:
- All cases use WIDTH=8.
- a=8'h5A, b=8'h23, start pulse -> done pulses exactly 9 edges after acceptance; diff=8'h37, borrow_out=0, ovf=0; busy high for 9 cycles.
- a=8'h00, b=8'h01 -> diff=8'hFF, borrow_out=1, ovf=0. Then a=8'h80, b=8'h01 -> diff=8'h7F, borrow_out=0, ovf=1.
- a=b=8'hFF -> diff=8'h00, borrow_out=0, ovf=0. Then a=8'h7F, b=8'h80 -> diff=8'hFF, borrow_out=1, ovf=1.
- Start with a=8'h10, b=8'h01, then pulse start with a=8'hFF, b=8'h00 at SHIFT cycle 3 and change a/b mid-operation -> second request ignored; diff=8'h0F; exactly one done pulse.
- Start a=8'hF0, b=8'h0F, then assert rst_n=0 for one edge at SHIFT cycle 4 -> all outputs 0, state IDLE, no done. A fresh start afterwards yields diff=8'hE1.
- Hold start=1 continuously with a=8'h09, b=8'h03 -> done pulses every 10 cycles, diff=8'h06 each time, and busy drops for exactly one cycle between operations.
